// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master between the CPU bridge (port 0) and
// the sensor poller (port 1); one command word per grant, watchdog-guarded.
module i2c_arbiter #(
    parameter int BUSY_BIT   = 31,
    parameter int START_WAIT = 16,
    parameter int TIMEOUT    = 1048575,
    parameter int CNT_W      = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [1:0]  rd,
    input  logic [31:0] cmd0,
    input  logic [31:0] cmd1,
    output logic [1:0]  grant,
    output logic [1:0]  done,
    output logic        err,
    output logic [31:0] rdata,
    output logic [31:0] m_ctrl_data,
    output logic        m_wr_ctrl,
    output logic        m_read,
    input  logic [31:0] m_status
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT_START, WAIT_DONE, DONE, COOL
    } state_t;

    localparam logic [CNT_W-1:0] START_LAST   = CNT_W'(START_WAIT - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             ptr;
    logic             owner;
    logic             pick;
    logic             busy;

    assign busy = m_status[BUSY_BIT];

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        // NOTE: assign a default first so every path drives pick and no latch is inferred.
        pick = ptr;
        if (req == 2'b01)
            pick = 1'b0;
        else if (req == 2'b10)
            pick = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            grant       <= 2'b00;
            done        <= 2'b00;
            err         <= 1'b0;
            rdata       <= '0;
            m_ctrl_data <= '0;
            m_wr_ctrl   <= 1'b0;
            m_read      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 2'b00) begin
                        owner       <= pick;
                        grant       <= pick ? 2'b10 : 2'b01;
                        m_ctrl_data <= pick ? cmd1 : cmd0;
                        m_read      <= rd[pick];
                        m_wr_ctrl   <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    m_wr_ctrl <= 1'b0;
                    cnt       <= '0;
                    state     <= WAIT_START;
                end
                WAIT_START: begin
                    if (busy) begin
                        cnt   <= '0;
                        state <= WAIT_DONE;
                    end else if (cnt == START_LAST) begin
                        done  <= grant;
                        err   <= 1'b1;
                        rdata <= m_status;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_DONE: begin
                    if (!busy) begin
                        done  <= grant;
                        err   <= 1'b0;
                        rdata <= m_status;
                        state <= DONE;
                    end else if (cnt == TIMEOUT_LAST) begin
                        done  <= grant;
                        err   <= 1'b1;
                        rdata <= m_status;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Hand the tie-break to the other port for the next arbitration.
                    ptr   <= ~owner;
                    done  <= 2'b00;
                    err   <= 1'b0;
                    grant <= 2'b00;
                    state <= COOL;
                end
                COOL: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
